seven_seg_scan_driver: RTL and testbench

Display back end for the duty-cycle/frequency readout. It consumes the digit stream from the digit-sequencing FSM: one 4-bit digit per cycle, tagged with an active-low position code of 0111, 1011, 1101, 1110, or 1111 for idle. It assembles the four digits into a complete frame and commits them atomically to a display buffer. It time-multiplexes the buffer onto a 4-digit common-anode 7-segment display with anti-ghosting blanking.

---
 rtl/display_pkg.sv | 39 +++
 rtl/seven_seg_scan_driver_if.sv | 39 +++
 rtl/bcd_to_7seg.sv | 32 +++
 rtl/seven_seg_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the 7-segment display back end: position-tag codes
// produced by the digit sequencer, the blank digit value, the capture FSM
// state type and the active-low segment patterns (bit 0 = a ... bit 6 = g).
// ---------------------------------------------------------------------------
package display_pkg;

    // Active-low position tags; one zero bit selects the digit slot.
    localparam logic [3:0] POS_D3   = 4'b0111;
    localparam logic [3:0] POS_D2   = 4'b1011;
    localparam logic [3:0] POS_D1   = 4'b1101;
    localparam logic [3:0] POS_D0   = 4'b1110;
    localparam logic [3:0] POS_IDLE = 4'b1111;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [1:0] {
        WAIT_D3 = 2'd0,
        WAIT_D2 = 2'd1,
        WAIT_D1 = 2'd2,
        WAIT_D0 = 2'd3
    } cap_state_t;

    // Active-low segment patterns, gfedcba.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver_if
// Bundles the digit stream from the sequencer and the display pins.
//   digit_in    4  digit value (0-9 numerals, A-E dash, F blank)
//   pos_code_in 4  active-low position tag, 1111 = idle
//   an          4  anode enables, active-low
//   seg         7  segments a..g, active-low
//   dp          1  decimal point, active-low
//   frame_tick  1  one-cycle pulse on frame commit
// master: sequencer / pin observer side.  slave: the scan driver.
// ---------------------------------------------------------------------------
interface seven_seg_scan_driver_if;

    logic [3:0] digit_in;
    logic [3:0] pos_code_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output digit_in,
        output pos_code_in,
        input  an,
        input  seg,
        input  dp,
        input  frame_tick
    );

    modport slave (
        input  digit_in,
        input  pos_code_in,
        output an,
        output seg,
        output dp,
        output frame_tick
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// bcd_to_7seg
// Combinational 4-bit digit to active-low 7-segment decoder.
//   digit  in  4  0-9 numerals, A-E dash, F blank
//   seg    out 7  segments a..g (bit 0 = a), active-low
// ---------------------------------------------------------------------------
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE: seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
// Assembles a four-digit frame from the tagged digit stream, commits it
// atomically to the display buffer and time-multiplexes the buffer onto a
// 4-digit common-anode display with blanking at the start of every slot.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  seven_seg_scan_driver_if.slave (digit stream in, display pins out)
// Parameters:
//   REFRESH_DIV   clock cycles per digit slot (>= 2, > BLANK_CYCLES)
//   BLANK_CYCLES  all-anodes-off cycles at the start of each slot (0 = none)
//   DP_MASK       bit i lights the decimal point of digit i
// ---------------------------------------------------------------------------
module seven_seg_scan_driver
    import display_pkg::*;
#(
    parameter int         REFRESH_DIV  = 50000,
    parameter int         BLANK_CYCLES = 16,
    parameter logic [3:0] DP_MASK      = 4'b0000
) (
    input  logic                    clk,
    input  logic                    rst,
    seven_seg_scan_driver_if.slave  bus
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);

    cap_state_t       state, state_nxt;
    logic             wr_d3, wr_d2, wr_d1, commit;
    logic [3:1][3:0]  stage;
    logic [3:0][3:0]  disp;
    logic             frame_tick_r;

    logic [PW-1:0]    presc;
    logic [1:0]       idx;
    logic             blank_slot;
    logic [6:0]       seg_dec;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;

    // Capture FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_D3;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture FSM: next state. Non one-hot-low codes are idle and hold.
    always_comb begin
        state_nxt = state;
        case (bus.pos_code_in)
            POS_D3: state_nxt = WAIT_D2;
            POS_D2: state_nxt = (state == WAIT_D2) ? WAIT_D1 : WAIT_D3;
            POS_D1: state_nxt = (state == WAIT_D1) ? WAIT_D0 : WAIT_D3;
            POS_D0: state_nxt = WAIT_D3;
            default: state_nxt = state;
        endcase
    end

    // Capture FSM: outputs (staging write enables and frame commit)
    always_comb begin
        wr_d3  = 1'b0;
        wr_d2  = 1'b0;
        wr_d1  = 1'b0;
        commit = 1'b0;
        case (bus.pos_code_in)
            POS_D3: wr_d3  = 1'b1;
            POS_D2: wr_d2  = (state == WAIT_D2);
            POS_D1: wr_d1  = (state == WAIT_D1);
            POS_D0: commit = (state == WAIT_D0);
            default: ;
        endcase
    end

    // Staging and display buffer; digit 0 goes straight from the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage        <= {3{DIGIT_BLANK}};
            disp         <= {4{DIGIT_BLANK}};
            frame_tick_r <= 1'b0;
        end else begin
            if (wr_d3) stage[3] <= bus.digit_in;
            if (wr_d2) stage[2] <= bus.digit_in;
            if (wr_d1) stage[1] <= bus.digit_in;
            if (commit) disp <= {stage[3], stage[2], stage[1], bus.digit_in};
            frame_tick_r <= commit;
        end
    end

    // Scan timing: prescaler and slot index, untouched by capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (presc == PRESC_TC) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank_slot = 1'b0;
        end else begin : g_blank
            assign blank_slot = (presc < PW'(BLANK_CYCLES));
        end
    endgenerate

    bcd_to_7seg u_dec (
        .digit (disp[idx]),
        .seg   (seg_dec)
    );

    // Registered pin drivers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r  <= 4'b1111;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else if (blank_slot) begin
            an_r  <= 4'b1111;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= ~(4'b0001 << idx);
            seg_r <= seg_dec;
            dp_r  <= ~DP_MASK[idx];
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_driver
// Directed bench for seven_seg_scan_driver with REFRESH_DIV=8,
// BLANK_CYCLES=2, DP_MASK=4'b0100. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   tick_cnt = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver_if bus ();

    seven_seg_scan_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .DP_MASK      (4'b0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.frame_tick === 1'b1) tick_cnt++;
    end

    task automatic drive(input logic [3:0] code, input logic [3:0] d);
        @(negedge clk);
        bus.pos_code_in = code;
        bus.digit_in    = d;
    endtask

    // Waits (bounded) for the slot of digit i to be lit.
    task automatic wait_lit(input int i, output bit ok);
        logic [3:0] tgt;
        tgt = ~(4'b0001 << i);
        ok  = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.an === tgt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pos_code_in = 4'b1111;
        bus.digit_in    = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.an !== 4'b1111 || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: an=%b seg=%b dp=%b tick=%b want an=1111 seg=1111111 dp=1 tick=0",
                     bus.an, bus.seg, bus.dp, bus.frame_tick);
        end
        rst = 1'b0;
    endtask

    // Starts right after reset release; display buffer is blank.
    task automatic test_scan();
        logic [3:0] exp_an;
        logic       exp_dp;
        int         slot, p;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            slot = (k - 1) / 8;
            p    = (k - 1) % 8;
            exp_an = (p < 2) ? 4'b1111 : ~(4'b0001 << (slot % 4));
            exp_dp = (p >= 2 && (slot % 4) == 2) ? 1'b0 : 1'b1;
            checks++;
            if (bus.an !== exp_an || bus.seg !== 7'h7F || bus.dp !== exp_dp) begin
                errors++;
                $display("FAIL scan_cycle%0d: an=%b seg=%b dp=%b want an=%b seg=1111111 dp=%b",
                         k, bus.an, bus.seg, bus.dp, exp_an, exp_dp);
            end
        end
    endtask

    task automatic test_frame();
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        bit         ok;
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        drive(4'b1111, 4'h0);
        drive(4'b0111, 4'h1);
        drive(4'b1011, 4'h2);
        drive(4'b1101, 4'h3);
        drive(4'b1110, 4'h4);
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL frame_tick_early: got %b want 0", bus.frame_tick);
        end
        @(negedge clk);
        bus.pos_code_in = 4'b1111;
        checks++;
        if (bus.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL frame_tick_pulse: got %b want 1", bus.frame_tick);
        end
        @(negedge clk);
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL frame_tick_width: got %b want 0", bus.frame_tick);
        end
        for (int i = 0; i < 4; i++) begin
            wait_lit(i, ok);
            checks++;
            if (!ok || bus.seg !== exp_seg[i] || bus.dp !== exp_dp[i]) begin
                errors++;
                $display("FAIL frame_digit%0d: lit=%0d seg=%b dp=%b want seg=%b dp=%b",
                         i, ok, bus.seg, bus.dp, exp_seg[i], exp_dp[i]);
            end
        end
    endtask

    task automatic test_out_of_order();
        logic [6:0] keep_seg [4];
        logic [6:0] new_seg  [4];
        int         c0;
        bit         ok;
        keep_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        new_seg  = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
        c0 = tick_cnt;
        drive(4'b0111, 4'h9);
        drive(4'b1101, 4'h5);
        drive(4'b1110, 4'h6);
        drive(4'b1111, 4'h0);
        @(negedge clk);
        checks++;
        if (tick_cnt - c0 !== 0) begin
            errors++;
            $display("FAIL ooo_no_tick: ticks=%0d want 0", tick_cnt - c0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_lit(i, ok);
            checks++;
            if (!ok || bus.seg !== keep_seg[i]) begin
                errors++;
                $display("FAIL ooo_disp_kept%0d: lit=%0d seg=%b want %b", i, ok, bus.seg, keep_seg[i]);
            end
        end
        c0 = tick_cnt;
        drive(4'b0111, 4'h5);
        drive(4'b1011, 4'h6);
        drive(4'b1101, 4'h7);
        drive(4'b1110, 4'h8);
        drive(4'b1111, 4'h0);
        @(negedge clk);
        checks++;
        if (tick_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL ooo_recover_tick: ticks=%0d want 1", tick_cnt - c0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_lit(i, ok);
            checks++;
            if (!ok || bus.seg !== new_seg[i]) begin
                errors++;
                $display("FAIL ooo_recover%0d: lit=%0d seg=%b want %b", i, ok, bus.seg, new_seg[i]);
            end
        end
    endtask

    task automatic test_restart();
        logic [6:0] exp_seg [4];
        int         c0;
        bit         ok;
        exp_seg = '{7'b1000000, 7'b1000000, 7'b0000000, 7'b1111000};
        c0 = tick_cnt;
        drive(4'b0111, 4'h1);
        drive(4'b1011, 4'h2);
        drive(4'b0111, 4'h7);
        drive(4'b1011, 4'h8);
        drive(4'b1101, 4'h0);
        drive(4'b1110, 4'h0);
        drive(4'b1111, 4'h0);
        @(negedge clk);
        checks++;
        if (tick_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL restart_ticks: ticks=%0d want 1", tick_cnt - c0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_lit(i, ok);
            checks++;
            if (!ok || bus.seg !== exp_seg[i]) begin
                errors++;
                $display("FAIL restart_digit%0d: lit=%0d seg=%b want %b", i, ok, bus.seg, exp_seg[i]);
            end
        end
    endtask

    task automatic test_idle_gaps();
        logic [6:0] exp_seg [4];
        int         c0;
        bit         ok;
        exp_seg = '{7'b0010000, 7'b0100100, 7'b1111111, 7'b0111111};
        c0 = tick_cnt;
        drive(4'b0111, 4'hA);
        drive(4'b1111, 4'h5);
        drive(4'b1011, 4'hF);
        drive(4'b0011, 4'h5);
        drive(4'b1101, 4'h2);
        drive(4'b1111, 4'h5);
        drive(4'b1110, 4'h9);
        drive(4'b1111, 4'h5);
        @(negedge clk);
        checks++;
        if (tick_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL gaps_ticks: ticks=%0d want 1", tick_cnt - c0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_lit(i, ok);
            checks++;
            if (!ok || bus.seg !== exp_seg[i]) begin
                errors++;
                $display("FAIL gaps_digit%0d: lit=%0d seg=%b want %b", i, ok, bus.seg, exp_seg[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic exp_dp [4];
        int   c0;
        bit   ok;
        exp_dp = '{1'b1, 1'b1, 1'b0, 1'b1};
        drive(4'b0111, 4'h3);
        drive(4'b1011, 4'h4);
        drive(4'b1111, 4'h0);
        wait_lit(1, ok);
        @(negedge clk);
        checks++;
        if (!ok || bus.seg !== 7'b0100100) begin
            errors++;
            $display("FAIL midreset_pre: lit=%0d seg=%b want 0100100", ok, bus.seg);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.an !== 4'b1111 || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async_blank: an=%b seg=%b dp=%b want 1111 1111111 1",
                     bus.an, bus.seg, bus.dp);
        end
        @(negedge clk);
        rst = 1'b0;
        c0 = tick_cnt;
        drive(4'b1101, 4'h5);
        drive(4'b1110, 4'h6);
        drive(4'b1111, 4'h0);
        @(negedge clk);
        checks++;
        if (tick_cnt - c0 !== 0) begin
            errors++;
            $display("FAIL midreset_partial_dropped: ticks=%0d want 0", tick_cnt - c0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_lit(i, ok);
            checks++;
            if (!ok || bus.seg !== 7'h7F || bus.dp !== exp_dp[i]) begin
                errors++;
                $display("FAIL midreset_digit%0d: lit=%0d seg=%b dp=%b want seg=1111111 dp=%b",
                         i, ok, bus.seg, bus.dp, exp_dp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_frame();
        test_out_of_order();
        test_restart();
        test_idle_gaps();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
